watch_timekeeper: RTL and testbench
===================================

WATCH_TIMEKEEPER -- requirements
Module: watch_timekeeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 32768: clk cycles per second, for both time-of-day and stopwatch (legal range >= 1).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port run_time, input, 1: level; 1 = time-of-day runs, 0 = time-set mode.
REQ-005 SHALL have port run_stopwatch, input, 1: level; 1 = stopwatch counts.
REQ-006 SHALL have port reset_stopwatch, input, 1: level; 1 = clear stopwatch.
REQ-007 SHALL have ports inc_h, dec_h, inc_m, dec_m, each input, 1: level adjust requests from the mode FSM.
REQ-008 SHALL have port hours, output, 5: time-of-day hours, 0-23.
REQ-009 SHALL have port minutes, output, 6: time-of-day minutes, 0-59.
REQ-010 SHALL have port seconds, output, 6: time-of-day seconds, 0-59.
REQ-011 SHALL have port sw_min, output, 7: stopwatch minutes, 0-99.
REQ-012 SHALL have port sw_sec, output, 6: stopwatch seconds, 0-59.
REQ-013 SHALL have port sec_tick, output, 1: one-cycle pulse on each time-of-day seconds advance.

Function
REQ-014 SHALL register all outputs; no combinational path from any input to any output.
REQ-015 SHALL keep the time prescaler counting 0..TICKS_PER_SEC-1 while run_time=1; wrap from TICKS_PER_SEC-1 to 0 advances seconds and pulses sec_tick in the same cycle.
REQ-016 SHALL clear the time prescaler and seconds to 0 while run_time=0; hours and minutes hold apart from adjusts; sec_tick stays 0.
REQ-017 SHALL carry on seconds 59->0 into minutes, minutes 59->0 into hours, and wrap hours 23->0.
REQ-018 SHALL detect each adjust input by rising edge: prior-cycle register, action on the clock edge where input=1 and prior=0; one step per edge regardless of how long the input is held.
REQ-019 SHALL act on adjusts only while run_time=0; edges while run_time=1 are ignored but still update the prior-cycle registers.
REQ-020 SHALL apply inc_h as hours+1 mod 24 and dec_h as hours-1 with 0->23.
REQ-021 SHALL apply inc_m as minutes+1 mod 60 and dec_m as minutes-1 with 0->59; no carry or borrow into hours.
REQ-022 SHALL leave a field unchanged when its inc and dec edges occur in the same cycle; hour and minute edges in the same cycle both apply.
REQ-023 SHALL run an independent stopwatch prescaler 0..TICKS_PER_SEC-1 while run_stopwatch=1; its wrap advances sw_sec.
REQ-024 SHALL carry sw_sec 59->0 into sw_min and wrap sw_min:sw_sec 99:59 -> 00:00.
REQ-025 SHALL hold the stopwatch prescaler, sw_sec and sw_min when run_stopwatch=0 (pause, not clear).
REQ-026 SHALL clear the stopwatch prescaler, sw_sec and sw_min on any cycle with reset_stopwatch=1, with priority over run_stopwatch.
REQ-027 SHALL make the stopwatch independent of run_time and all adjust inputs.

Reset
REQ-028 SHALL on reset=0, without waiting for a clock edge, set hours, minutes, seconds, sw_min and sw_sec to 0, sec_tick to 0, both prescalers to 0, and all edge-detect prior registers to 0.
REQ-029 SHALL resume normal counting on the first rising clk edge after reset returns to 1; reset asserted mid-count discards any partial prescaler count.

Verification (TICKS_PER_SEC=4 unless stated)
REQ-030 SHALL cover: reset, run_time=1 for 240 cycles -> 00:01:00, and sec_tick pulses exactly 60 times.
REQ-031 SHALL cover: run_time=0, then one dec_h edge and one dec_m edge -> 23:59:00; then run_time=1 for 240 cycles -> 00:00:00.
REQ-032 SHALL cover: run_time=0, inc_h held high 10 cycles -> hours +1 only; inc_m and dec_m both rising in the same cycle -> minutes unchanged; inc_h with run_time=1 -> hours unchanged.
REQ-033 SHALL cover the stopwatch: run_stopwatch=1 for 12 cycles -> sw_sec=3; run_stopwatch=0 for 20 cycles -> still 3; reset_stopwatch=1 together with run_stopwatch=1 for 8 cycles -> 00:00 throughout.
REQ-034 SHALL cover, with TICKS_PER_SEC=1: run_stopwatch=1 for 5999 cycles -> 99:59, and the next cycle -> 00:00.
REQ-035 SHALL cover: reset driven low mid-second between clock edges -> all outputs 0 immediately; after release, the first seconds advance occurs exactly 4 cycles later.

Source files
------------

// File: rtl/watch_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : watch_timekeeper
// Description : Time-of-day clock (HH:MM:SS, 24 h) with a time-set mode and an
//               independent 99:59 stopwatch, both driven from one clk through
//               their own TICKS_PER_SEC prescalers.
// Ports       : clk             - single clock, rising edge
//               reset           - asynchronous, active-low
//               run_time        - 1 = time-of-day runs, 0 = time-set mode
//               run_stopwatch   - 1 = stopwatch counts, 0 = paused
//               reset_stopwatch - 1 = clear stopwatch (wins over run)
//               inc_h/dec_h/inc_m/dec_m - adjust requests, rising-edge active
//               hours/minutes/seconds   - time of day
//               sw_min/sw_sec           - stopwatch
//               sec_tick        - one-cycle pulse on each seconds advance
// Revision    : 1.0 - initial release
// ============================================================================
module watch_timekeeper #(
    parameter int TICKS_PER_SEC = 32768
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_time,
    input  logic       run_stopwatch,
    input  logic       reset_stopwatch,
    input  logic       inc_h,
    input  logic       dec_h,
    input  logic       inc_m,
    input  logic       dec_m,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [6:0] sw_min,
    output logic [5:0] sw_sec,
    output logic       sec_tick
);

    localparam int                 c_PRE_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_TOP = c_PRE_W'(TICKS_PER_SEC - 1);

    logic [c_PRE_W-1:0] r_tpre;
    logic [c_PRE_W-1:0] r_swpre;
    logic [4:0]         r_hours;
    logic [5:0]         r_minutes;
    logic [5:0]         r_seconds;
    logic [6:0]         r_sw_min;
    logic [5:0]         r_sw_sec;
    logic               r_sec_tick;
    logic               r_inc_h_q, r_dec_h_q, r_inc_m_q, r_dec_m_q;

    logic               w_inc_h, w_dec_h, w_inc_m, w_dec_m;
    logic               w_tod_wrap;
    logic               w_sw_wrap;
    logic [4:0]         w_hours_nxt;
    logic [5:0]         w_minutes_nxt;

    // Rising-edge detection; the prior-cycle registers track the inputs in
    // every mode so an edge seen while running is never replayed later.
    assign w_inc_h    = inc_h & ~r_inc_h_q;
    assign w_dec_h    = dec_h & ~r_dec_h_q;
    assign w_inc_m    = inc_m & ~r_inc_m_q;
    assign w_dec_m    = dec_m & ~r_dec_m_q;

    assign w_tod_wrap = run_time && (r_tpre == c_PRE_TOP);
    assign w_sw_wrap  = run_stopwatch && (r_swpre == c_PRE_TOP);

    // Hours/minutes next value: carries while running, adjusts while setting.
    // Opposing edges on one field in the same cycle cancel out.
    always_comb begin
        w_hours_nxt   = r_hours;
        w_minutes_nxt = r_minutes;
        if (run_time) begin
            if (w_tod_wrap && (r_seconds == 6'd59)) begin
                if (r_minutes == 6'd59) begin
                    w_minutes_nxt = 6'd0;
                    w_hours_nxt   = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
                end else begin
                    w_minutes_nxt = r_minutes + 6'd1;
                end
            end
        end else begin
            if (w_inc_h && !w_dec_h) begin
                w_hours_nxt = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
            end else if (w_dec_h && !w_inc_h) begin
                w_hours_nxt = (r_hours == 5'd0) ? 5'd23 : r_hours - 5'd1;
            end
            if (w_inc_m && !w_dec_m) begin
                w_minutes_nxt = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
            end else if (w_dec_m && !w_inc_m) begin
                w_minutes_nxt = (r_minutes == 6'd0) ? 6'd59 : r_minutes - 6'd1;
            end
        end
    end

    // Time of day
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tpre     <= '0;
            r_hours    <= 5'd0;
            r_minutes  <= 6'd0;
            r_seconds  <= 6'd0;
            r_sec_tick <= 1'b0;
            r_inc_h_q  <= 1'b0;
            r_dec_h_q  <= 1'b0;
            r_inc_m_q  <= 1'b0;
            r_dec_m_q  <= 1'b0;
        end else begin
            r_inc_h_q <= inc_h;
            r_dec_h_q <= dec_h;
            r_inc_m_q <= inc_m;
            r_dec_m_q <= dec_m;
            r_hours   <= w_hours_nxt;
            r_minutes <= w_minutes_nxt;
            if (!run_time) begin
                r_tpre     <= '0;
                r_seconds  <= 6'd0;
                r_sec_tick <= 1'b0;
            end else if (w_tod_wrap) begin
                r_tpre     <= '0;
                r_seconds  <= (r_seconds == 6'd59) ? 6'd0 : r_seconds + 6'd1;
                r_sec_tick <= 1'b1;
            end else begin
                r_tpre     <= r_tpre + 1'b1;
                r_sec_tick <= 1'b0;
            end
        end
    end

    // Stopwatch: fully independent of the time-of-day controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_swpre  <= '0;
            r_sw_min <= 7'd0;
            r_sw_sec <= 6'd0;
        end else if (reset_stopwatch) begin
            r_swpre  <= '0;
            r_sw_min <= 7'd0;
            r_sw_sec <= 6'd0;
        end else if (run_stopwatch) begin
            if (w_sw_wrap) begin
                r_swpre <= '0;
                if (r_sw_sec == 6'd59) begin
                    r_sw_sec <= 6'd0;
                    r_sw_min <= (r_sw_min == 7'd99) ? 7'd0 : r_sw_min + 7'd1;
                end else begin
                    r_sw_sec <= r_sw_sec + 6'd1;
                end
            end else begin
                r_swpre <= r_swpre + 1'b1;
            end
        end
    end

    assign hours    = r_hours;
    assign minutes  = r_minutes;
    assign seconds  = r_seconds;
    assign sw_min   = r_sw_min;
    assign sw_sec   = r_sw_sec;
    assign sec_tick = r_sec_tick;

endmodule
`default_nettype wire

// File: tb/tb_watch_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_watch_timekeeper
// Description : Directed self-checking bench for watch_timekeeper. One DUT at
//               TICKS_PER_SEC=4 exercises time of day, adjusts and stopwatch;
//               a second at TICKS_PER_SEC=1 covers the 99:59 stopwatch wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_watch_timekeeper;

    logic       clk;
    logic       reset;
    logic       run_time, run_stopwatch, reset_stopwatch;
    logic       inc_h, dec_h, inc_m, dec_m;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [6:0] sw_min;
    logic [5:0] sw_sec;
    logic       sec_tick;

    logic       sw1_run;
    logic [4:0] h1;
    logic [5:0] m1, s1;
    logic [6:0] sw1_min;
    logic [5:0] sw1_sec;
    logic       tick1;

    watch_timekeeper #(.TICKS_PER_SEC(4)) u_dut (
        .clk(clk), .reset(reset), .run_time(run_time),
        .run_stopwatch(run_stopwatch), .reset_stopwatch(reset_stopwatch),
        .inc_h(inc_h), .dec_h(dec_h), .inc_m(inc_m), .dec_m(dec_m),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .sw_min(sw_min), .sw_sec(sw_sec), .sec_tick(sec_tick)
    );

    watch_timekeeper #(.TICKS_PER_SEC(1)) u_dut1 (
        .clk(clk), .reset(reset), .run_time(1'b0),
        .run_stopwatch(sw1_run), .reset_stopwatch(1'b0),
        .inc_h(1'b0), .dec_h(1'b0), .inc_m(1'b0), .dec_m(1'b0),
        .hours(h1), .minutes(m1), .seconds(s1),
        .sw_min(sw1_min), .sw_sec(sw1_sec), .sec_tick(tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_cnt = 0;

    function automatic logic [31:0] pack_t(input int h, input int m, input int s);
        return 32'((h << 12) | (m << 6) | s);
    endfunction

    function automatic logic [31:0] pack_sw(input int m, input int s);
        return 32'((m << 6) | s);
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0x%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp)
            else begin
                n_fail++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [31:0] obs_t();
        return pack_t(int'(hours), int'(minutes), int'(seconds));
    endfunction

    function automatic logic [31:0] obs_sw();
        return pack_sw(int'(sw_min), int'(sw_sec));
    endfunction

    // Advance n rising edges, sampling 1 time unit after each; sec_tick pulses
    // are counted once per cycle.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sec_tick === 1'b1) tick_cnt++;
        end
    endtask

    initial begin
        reset = 1'b0;
        run_time = 1'b0; run_stopwatch = 1'b0; reset_stopwatch = 1'b0;
        inc_h = 1'b0; dec_h = 1'b0; inc_m = 1'b0; dec_m = 1'b0;
        sw1_run = 1'b0;

        // Reset state
        #12;
        expect_val("reset_time", pack_t(0, 0, 0));    check(obs_t());
        expect_val("reset_sw", pack_sw(0, 0));        check(obs_sw());
        expect_val("reset_tick", 32'd0);              check(32'(sec_tick));

        // 240 cycles of running time -> one minute, 60 pulses
        tick(1);
        reset = 1'b1;
        run_time = 1'b1;
        tick_cnt = 0;
        tick(240);
        expect_val("run_1min", pack_t(0, 1, 0));      check(obs_t());
        expect_val("tick_count", 32'd60);             check(32'(tick_cnt));

        // Fresh reset, then dec_h and dec_m together -> 23:59:00
        run_time = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        dec_h = 1'b1; dec_m = 1'b1;
        tick(1);
        dec_h = 1'b0; dec_m = 1'b0;
        tick(1);
        expect_val("dec_wrap", pack_t(23, 59, 0));    check(obs_t());
        run_time = 1'b1;
        tick(240);
        expect_val("day_wrap", pack_t(0, 0, 0));      check(obs_t());

        // Leaving run mode clears seconds and suppresses sec_tick
        tick(6);
        expect_val("run_6cyc", pack_t(0, 0, 1));      check(obs_t());
        run_time = 1'b0;
        tick(1);
        expect_val("set_clears_sec", pack_t(0, 0, 0)); check(obs_t());
        expect_val("set_no_tick", 32'd0);             check(32'(sec_tick));

        // Held inc_h steps once
        inc_h = 1'b1;
        tick(10);
        expect_val("inc_h_held", pack_t(1, 0, 0));    check(obs_t());
        inc_h = 1'b0;
        tick(1);

        // inc_m and dec_m in the same cycle cancel
        inc_m = 1'b1; dec_m = 1'b1;
        tick(1);
        expect_val("inc_dec_m_same", pack_t(1, 0, 0)); check(obs_t());
        inc_m = 1'b0; dec_m = 1'b0;
        tick(1);

        // Minute wrap without borrow/carry into hours
        dec_m = 1'b1;
        tick(1);
        expect_val("dec_m_wrap", pack_t(1, 59, 0));   check(obs_t());
        dec_m = 1'b0;
        tick(1);
        inc_m = 1'b1;
        tick(1);
        expect_val("inc_m_wrap", pack_t(1, 0, 0));    check(obs_t());
        inc_m = 1'b0;
        tick(1);

        // inc_h edge while running is ignored, and not replayed on entering set
        run_time = 1'b1;
        inc_h = 1'b1;
        tick(1);
        expect_val("inc_h_running", pack_t(1, 0, 0)); check(obs_t());
        run_time = 1'b0;
        tick(1);
        expect_val("inc_h_no_replay", pack_t(1, 0, 0)); check(obs_t());
        inc_h = 1'b0;
        tick(1);

        // Stopwatch run / pause / clear-with-priority
        run_stopwatch = 1'b1;
        tick(12);
        expect_val("sw_run12", pack_sw(0, 3));        check(obs_sw());
        run_stopwatch = 1'b0;
        tick(20);
        expect_val("sw_pause", pack_sw(0, 3));        check(obs_sw());
        reset_stopwatch = 1'b1;
        run_stopwatch = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            expect_val("sw_clear", pack_sw(0, 0));    check(obs_sw());
        end
        reset_stopwatch = 1'b0;
        run_stopwatch = 1'b0;
        expect_val("sw_time_untouched", pack_t(1, 0, 0)); check(obs_t());

        // TICKS_PER_SEC=1 stopwatch full-range wrap
        sw1_run = 1'b1;
        tick(5999);
        expect_val("sw1_9959", pack_sw(99, 59));
        check(pack_sw(int'(sw1_min), int'(sw1_sec)));
        tick(1);
        expect_val("sw1_wrap", pack_sw(0, 0));
        check(pack_sw(int'(sw1_min), int'(sw1_sec)));
        sw1_run = 1'b0;

        // Asynchronous reset mid-second, then exact first-second latency
        run_time = 1'b1;
        run_stopwatch = 1'b1;
        tick(6);
        expect_val("pre_reset_time", pack_t(1, 0, 1)); check(obs_t());
        #3;
        reset = 1'b0;
        #1;
        expect_val("async_time", pack_t(0, 0, 0));    check(obs_t());
        expect_val("async_sw", pack_sw(0, 0));        check(obs_sw());
        expect_val("async_tick", 32'd0);              check(32'(sec_tick));
        reset = 1'b1;
        run_stopwatch = 1'b0;
        tick(3);
        expect_val("post_reset_3", pack_t(0, 0, 0));  check(obs_t());
        tick(1);
        expect_val("post_reset_4", pack_t(0, 0, 1));  check(obs_t());
        expect_val("post_reset_tick", 32'd1);         check(32'(sec_tick));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
